axis_restoring_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 34 +++
 rtl/div_stage.sv | 36 +++
 rtl/axis_restoring_divider.sv | 106 ++++++++++
 tb/tb_axis_restoring_divider.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and the per-stage record for the pipelined restoring divider.
// Every divide stage passes one stage_t to the next.
package divider_pkg;

  localparam int WIDTH     = 8;
  localparam int FRAC_BITS = 8;
  localparam int LATENCY   = WIDTH + FRAC_BITS;
  localparam int QW        = WIDTH + FRAC_BITS;

  typedef struct packed {
    logic             valid;
    logic             dbz;
    logic [WIDTH:0]   rem;
    logic [QW-1:0]    quot;
    logic [WIDTH-1:0] divisor;
  } stage_t;

  localparam stage_t STAGE_IDLE = stage_t'({$bits(stage_t){1'b0}});

  // The quotient field starts out holding the shifted dividend.
  // Each stage shifts one numerator bit out of the top and one quotient bit in at the bottom.
  function automatic stage_t stage_seed(input logic             valid,
                                        input logic [WIDTH-1:0] dividend,
                                        input logic [WIDTH-1:0] divisor);
    stage_t s;
    s.valid   = valid;
    s.dbz     = (divisor == {WIDTH{1'b0}});
    s.rem     = {(WIDTH+1){1'b0}};
    s.quot    = {dividend, {FRAC_BITS{1'b0}}};
    s.divisor = divisor;
    return s;
  endfunction

endpackage

// File: rtl/div_stage.sv
// One registered restoring-division step.
// It shifts the next numerator bit into the partial remainder, trial-subtracts, and restores when the result is negative.
module div_stage
  import divider_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rstn,
  input  stage_t i_stage,
  output stage_t o_stage
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;
  logic           take_s;
  stage_t         next_s;

  // Trial subtract. A set remainder MSB means the shifted value already exceeds any divisor.
  always_comb begin
    trial_s     = {i_stage.rem[WIDTH-1:0], i_stage.quot[QW-1]};
    diff_s      = trial_s - {1'b0, i_stage.divisor};
    take_s      = i_stage.rem[WIDTH] | (trial_s >= {1'b0, i_stage.divisor});
    next_s      = i_stage;
    next_s.rem  = take_s ? diff_s : trial_s;
    next_s.quot = {i_stage.quot[QW-2:0], take_s};
  end

  // Stage register. A reset drops whatever is in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_stage <= STAGE_IDLE;
    end else begin
      o_stage <= next_s;
    end
  end

endmodule

// File: rtl/axis_restoring_divider.sv
// Fully pipelined 8.8 unsigned divider with single-entry operand pairing and no backpressure.
// It accepts one division per clock and returns each result LATENCY cycles after issue.
module axis_restoring_divider
  import divider_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [WIDTH-1:0]           i_dividend_tdata,
  input  logic                       i_dividend_tvalid,
  input  logic [WIDTH-1:0]           i_divisor_tdata,
  input  logic                       i_divisor_tvalid,
  output logic [WIDTH+FRAC_BITS-1:0] o_dout_tdata,
  output logic                       o_dout_tvalid,
  output logic                       o_dout_tuser
);

  logic [WIDTH-1:0] dividend_hold_r;
  logic [WIDTH-1:0] divisor_hold_r;
  logic             dividend_full_r;
  logic             divisor_full_r;

  logic             issue_s;
  logic [WIDTH-1:0] issue_dividend_s;
  logic [WIDTH-1:0] issue_divisor_s;

  stage_t           pipe_s [LATENCY+1];

  // Issue selection. A live pair wins; a lone beat pairs with the other channel's held value.
  always_comb begin
    issue_s          = 1'b0;
    issue_dividend_s = i_dividend_tdata;
    issue_divisor_s  = i_divisor_tdata;
    if (i_dividend_tvalid && i_divisor_tvalid) begin
      issue_s = 1'b1;
    end else if (i_dividend_tvalid) begin
      if (divisor_full_r) begin
        issue_s         = 1'b1;
        issue_divisor_s = divisor_hold_r;
      end else begin
        issue_s = 1'b0;
      end
    end else if (i_divisor_tvalid) begin
      if (dividend_full_r) begin
        issue_s          = 1'b1;
        issue_dividend_s = dividend_hold_r;
      end else begin
        issue_s = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  // Holding registers. The newest lone beat overwrites; a held value survives a live pair.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      dividend_hold_r <= {WIDTH{1'b0}};
      divisor_hold_r  <= {WIDTH{1'b0}};
      dividend_full_r <= 1'b0;
      divisor_full_r  <= 1'b0;
    end else if (i_dividend_tvalid && !i_divisor_tvalid) begin
      if (divisor_full_r) begin
        divisor_full_r <= 1'b0;
      end else begin
        dividend_hold_r <= i_dividend_tdata;
        dividend_full_r <= 1'b1;
      end
    end else if (i_divisor_tvalid && !i_dividend_tvalid) begin
      if (dividend_full_r) begin
        dividend_full_r <= 1'b0;
      end else begin
        divisor_hold_r <= i_divisor_tdata;
        divisor_full_r <= 1'b1;
      end
    end else begin
      dividend_hold_r <= dividend_hold_r;
      divisor_hold_r  <= divisor_hold_r;
    end
  end

  assign pipe_s[0] = stage_seed(issue_s, issue_dividend_s, issue_divisor_s);

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    div_stage u_stage (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_stage (pipe_s[k]),
      .o_stage (pipe_s[k+1])
    );
  end

  // Output register. Data and flag are forced to zero whenever no result is presented.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_dout_tvalid <= 1'b0;
      o_dout_tuser  <= 1'b0;
      o_dout_tdata  <= {QW{1'b0}};
    end else begin
      o_dout_tvalid <= pipe_s[LATENCY].valid;
      o_dout_tuser  <= pipe_s[LATENCY].valid & pipe_s[LATENCY].dbz;
      o_dout_tdata  <= (pipe_s[LATENCY].valid && !pipe_s[LATENCY].dbz) ?
                       pipe_s[LATENCY].quot : {QW{1'b0}};
    end
  end

endmodule

// File: tb/tb_axis_restoring_divider.sv
// Randomised and directed bench for axis_restoring_divider.
// A behavioural pairing and arithmetic model predicts every output cycle.
module tb_axis_restoring_divider;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [7:0]  i_dividend_tdata;
  logic        i_dividend_tvalid;
  logic [7:0]  i_divisor_tdata;
  logic        i_divisor_tvalid;
  logic [15:0] o_dout_tdata;
  logic        o_dout_tvalid;
  logic        o_dout_tuser;

  always #5 i_clk = ~i_clk;

  axis_restoring_divider dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_dividend_tdata  (i_dividend_tdata),
    .i_dividend_tvalid (i_dividend_tvalid),
    .i_divisor_tdata   (i_divisor_tdata),
    .i_divisor_tvalid  (i_divisor_tvalid),
    .o_dout_tdata      (o_dout_tdata),
    .o_dout_tvalid     (o_dout_tvalid),
    .o_dout_tuser      (o_dout_tuser)
  );

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        u;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   issued = 0;
  int   observed = 0;
  logic [7:0] hold_a, hold_b;
  bit   full_a = 1'b0, full_b = 1'b0;

  function automatic logic [15:0] ref_quot(input int a, input int b);
    if (b == 0) return 16'h0000;
    return 16'((a * 256) / b);
  endfunction

  // Reference model: pair operands at each rising edge and schedule the result 16 cycles later
  always @(posedge i_clk) begin
    bit   iss;
    int   a, b;
    res_t r;
    cyc++;
    iss = 1'b0;
    a = int'(i_dividend_tdata);
    b = int'(i_divisor_tdata);
    if (!i_rstn) begin
      issued -= exp_q.size();
      exp_q.delete();
      full_a = 1'b0;
      full_b = 1'b0;
    end else if (i_dividend_tvalid && i_divisor_tvalid) begin
      iss = 1'b1;
    end else if (i_dividend_tvalid) begin
      if (full_b) begin iss = 1'b1; b = int'(hold_b); full_b = 1'b0; end
      else begin hold_a = i_dividend_tdata; full_a = 1'b1; end
    end else if (i_divisor_tvalid) begin
      if (full_a) begin iss = 1'b1; a = int'(hold_a); full_a = 1'b0; end
      else begin hold_b = i_divisor_tdata; full_b = 1'b1; end
    end
    if (iss) begin
      r.cyc = cyc + 16;
      r.d   = ref_quot(a, b);
      r.u   = (b == 0);
      exp_q.push_back(r);
      issued++;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge i_clk) begin
    logic        ev;
    logic [15:0] ed;
    logic        eu;
    res_t        o;
    if (cyc > 0) begin
      ev = 1'b0; ed = 16'h0000; eu = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = 1'b1; ed = exp_q[0].d; eu = exp_q[0].u;
        void'(exp_q.pop_front());
      end
      checks++;
      if ({o_dout_tvalid, o_dout_tdata, o_dout_tuser} !== {ev, ed, eu}) begin
        errors++;
        $display("FAIL out cyc=%0d got v=%0b d=%h u=%0b expected v=%0b d=%h u=%0b",
                 cyc, o_dout_tvalid, o_dout_tdata, o_dout_tuser, ev, ed, eu);
      end
      if (o_dout_tvalid === 1'b1) begin
        observed++;
        o.cyc = cyc; o.d = o_dout_tdata; o.u = o_dout_tuser;
        obs_q.push_back(o);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] a, input logic sv, input logic [7:0] b);
    i_dividend_tvalid = dv; i_dividend_tdata = a;
    i_divisor_tvalid  = sv; i_divisor_tdata  = b;
    @(posedge i_clk); #1;
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  initial begin
    int t;
    i_rstn = 1'b0;
    i_dividend_tvalid = 1'b0; i_dividend_tdata = 8'h00;
    i_divisor_tvalid  = 1'b0; i_divisor_tdata  = 8'h00;
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    check("reset_tvalid", int'(o_dout_tvalid), 0);

    check("pin_200_3", int'(ref_quot(200, 3)), 'h42AA);
    check("pin_1_255", int'(ref_quot(1, 255)), 'h0001);
    check("pin_50_4",  int'(ref_quot(50, 4)),  'h0C80);

    obs_q.delete();
    step(1'b1, 8'd200, 1'b1, 8'd3); t = cyc;
    idle(20);
    check("simul_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("simul_data", int'(obs_q[0].d), 'h42AA);
      check("simul_user", int'(obs_q[0].u), 0);
      check("simul_lat",  obs_q[0].cyc, t + 16);
    end

    obs_q.delete();
    step(1'b1, 8'd255, 1'b1, 8'd1); t = cyc;
    step(1'b1, 8'd0,   1'b1, 8'd7);
    step(1'b1, 8'd1,   1'b1, 8'd255);
    idle(20);
    check("b2b_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("b2b_d0", int'(obs_q[0].d), 'hFF00);
      check("b2b_d1", int'(obs_q[1].d), 'h0000);
      check("b2b_d2", int'(obs_q[2].d), 'h0001);
      check("b2b_lat", obs_q[2].cyc, t + 18);
    end

    obs_q.delete();
    step(1'b1, 8'd5,  1'b1, 8'd0);
    step(1'b1, 8'd10, 1'b1, 8'd4);
    idle(20);
    check("dbz_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("dbz_d0", int'(obs_q[0].d), 'h0000);
      check("dbz_u0", int'(obs_q[0].u), 1);
      check("dbz_d1", int'(obs_q[1].d), 'h0280);
      check("dbz_u1", int'(obs_q[1].u), 0);
    end

    obs_q.delete();
    step(1'b1, 8'd100, 1'b0, 8'd0);
    idle(1);
    step(1'b1, 8'd50, 1'b0, 8'd0);
    idle(2);
    step(1'b0, 8'd0, 1'b1, 8'd4); t = cyc;
    idle(20);
    check("split_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("split_data", int'(obs_q[0].d), 'h0C80);
      check("split_lat",  obs_q[0].cyc, t + 16);
    end

    obs_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b1, 8'($urandom));
    step(1'b1, 8'd77, 1'b0, 8'd0);
    i_rstn = 1'b0;
    idle(1);
    i_rstn = 1'b1;
    check("rst_tvalid", int'(o_dout_tvalid), 0);
    step(1'b0, 8'd0, 1'b1, 8'd9);
    idle(25);
    check("rst_no_pulse", obs_q.size(), 0);
    step(1'b1, 8'd90, 1'b0, 8'd0);
    idle(20);
    check("rst_held_pair", obs_q.size(), 1);
    if (obs_q.size() == 1) check("rst_held_data", int'(obs_q[0].d), 'h0A00);

    for (int i = 0; i < 12000; i++) begin
      logic       dv, sv;
      logic [7:0] b;
      dv = ($urandom_range(0, 2) != 0);
      sv = ($urandom_range(0, 2) != 0);
      b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      step(dv, 8'($urandom), sv, b);
      if (obs_q.size() > 64) obs_q.delete();
    end
    idle(20);
    check("drain_empty", exp_q.size(), 0);
    check("total_count", observed, issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
